// File: rtl/xbus_mc.sv
// Multicast row bus: broadcasts a tagged value to every PE whose scan-loaded ID
// matches the tag under a don't-care mask, with independent per-PE delivery.
module xbus_mc #(
  parameter int PE_NUMS   = 14,
  parameter int ID_LEN    = 5,
  parameter int VALUE_LEN = 32,
  parameter int CNT_LEN   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  output logic                        ready,
  input  logic [ID_LEN+VALUE_LEN-1:0] tag_value,
  input  logic [ID_LEN-1:0]           tag_mask,
  input  logic                        set_id,
  input  logic [ID_LEN-1:0]           id_scan_in,
  output logic [ID_LEN-1:0]           id_scan_out,
  output logic [VALUE_LEN-1:0]        pe_value,
  output logic [PE_NUMS-1:0]          pe_enable,
  input  logic [PE_NUMS-1:0]          pe_ready,
  output logic                        busy,
  output logic [CNT_LEN-1:0]          miss_count
);

  logic [ID_LEN-1:0]    id [PE_NUMS];
  logic [ID_LEN-1:0]    tag_id;
  logic [VALUE_LEN-1:0] value;
  logic [PE_NUMS-1:0]   bitmap;
  logic                 accept;

  assign tag_id      = tag_value[ID_LEN+VALUE_LEN-1:VALUE_LEN];
  assign value       = tag_value[VALUE_LEN-1:0];
  assign id_scan_out = id[PE_NUMS-1];
  assign busy        = |pe_enable;

  // Handshake: a tag transfers on a rising edge where enable && ready. ready is
  // combinational: the stage can be replaced only if every still-pending PE is
  // consuming this cycle, and never while the ID chain is shifting.
  assign ready  = !set_id && ((pe_enable & ~pe_ready) == '0);
  assign accept = enable && ready;

  always_comb begin
    bitmap = '0;
    for (int i = 0; i < PE_NUMS; i++) begin
      bitmap[i] = (((id[i] ^ tag_id) & ~tag_mask) == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PE_NUMS; i++) id[i] <= '0;
    end else if (set_id) begin
      id[0] <= id_scan_in;
      for (int i = 1; i < PE_NUMS; i++) id[i] <= id[i-1];
    end
  end

  // The target bitmap is captured at accept, so later ID shifts cannot retarget it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe_enable <= '0;
      pe_value  <= '0;
    end else if (accept && (bitmap != '0)) begin
      pe_enable <= bitmap;
      pe_value  <= value;
    end else begin
      pe_enable <= pe_enable & ~pe_ready;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_count <= '0;
    end else if (accept && (bitmap == '0) && (miss_count != '1)) begin
      miss_count <= miss_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_xbus_mc.sv
// Bench for xbus_mc: directed test-plan scenarios plus random traffic, checked
// by a per-PE delivery scoreboard fed from a tag-matching reference model.
module tb_xbus_mc;

  localparam int N = 14;
  localparam logic [N-1:0] ALL = 14'h3FFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        ready;
  logic [36:0] tag_value = '0;
  logic [4:0]  tag_mask = '0;
  logic        set_id = 1'b0;
  logic [4:0]  id_scan_in = '0;
  logic [4:0]  id_scan_out;
  logic [31:0] pe_value;
  logic [N-1:0] pe_enable;
  logic [N-1:0] pe_ready = '0;
  logic        busy;
  logic [15:0] miss_count;

  xbus_mc #(.PE_NUMS(14), .ID_LEN(5), .VALUE_LEN(32), .CNT_LEN(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ready(ready),
    .tag_value(tag_value), .tag_mask(tag_mask), .set_id(set_id),
    .id_scan_in(id_scan_in), .id_scan_out(id_scan_out), .pe_value(pe_value),
    .pe_enable(pe_enable), .pe_ready(pe_ready), .busy(busy),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] exp_q [N][$];
  logic [4:0]  mid [N];
  logic [15:0] miss_exp = '0;
  logic [31:0] last_val = '0;
  logic [N-1:0] exp_bm;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] targets(input logic [4:0] tid, input logic [4:0] msk);
    logic [N-1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) begin
      t[i] = 1'b1;
      for (int b = 0; b < 5; b++)
        if (!msk[b] && (mid[i][b] != tid[b])) t[i] = 1'b0;
    end
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      mid[i] = '0;
    end
    miss_exp = '0;
    last_val = '0;
  endtask

  // Monitor: outputs are stable at negedge; deliveries happen at the next posedge.
  always @(negedge clk) begin
    exp_bm = '0;
    for (int i = 0; i < N; i++) exp_bm[i] = (exp_q[i].size() != 0);
    chk("pe_enable", 64'(pe_enable), 64'(exp_bm));
    chk("busy", 64'(busy), 64'(|exp_bm));
    chk("pe_value", 64'(pe_value), 64'(last_val));
    chk("miss_count", 64'(miss_count), 64'(miss_exp));
    chk("id_scan_out", 64'(id_scan_out), 64'(mid[N-1]));
    for (int i = 0; i < N; i++) begin
      if (rst && pe_ready[i] && exp_q[i].size() != 0) begin
        chk("deliver_value", 64'(pe_value), 64'(exp_q[i][0]));
        void'(exp_q[i].pop_front());
      end
    end
  end

  // Driver: one cycle of stimulus, then issue the expected outcome to the model.
  task automatic step(input logic en, input logic [4:0] tid, input logic [31:0] val,
                      input logic [4:0] msk, input logic sid, input logic [4:0] sin,
                      input logic [N-1:0] prdy);
    logic exp_ready;
    logic [N-1:0] t;
    @(posedge clk); #1;
    enable = en; tag_value = {tid, val}; tag_mask = msk;
    set_id = sid; id_scan_in = sin; pe_ready = prdy;
    @(negedge clk); #1;
    exp_ready = !sid;
    for (int i = 0; i < N; i++)
      if (exp_q[i].size() != 0 && !prdy[i]) exp_ready = 1'b0;
    chk("ready", 64'(ready), 64'(exp_ready));
    if (en && exp_ready) begin
      t = targets(tid, msk);
      if (t == '0) begin
        if (miss_exp != 16'hFFFF) miss_exp = miss_exp + 16'd1;
      end else begin
        last_val = val;
        for (int i = 0; i < N; i++) if (t[i]) exp_q[i].push_back(val);
      end
    end
    if (sid) begin
      for (int i = N - 1; i > 0; i--) mid[i] = mid[i-1];
      mid[0] = sin;
    end
  endtask

  task automatic idle(input logic [N-1:0] prdy);
    step(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 5'd0, prdy);
  endtask

  task automatic load_ids_descending();
    for (int k = 0; k < N; k++) step(1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 5'(N - 1 - k), ALL);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    chk("rst_pe_enable", 64'(pe_enable), 64'd0);
    chk("rst_miss_count", 64'(miss_count), 64'd0);
    #1 rst = 1'b1;

    // Scan load: id[i] = i
    load_ids_descending();
    idle(ALL);
    chk("scan_out_loaded", 64'(id_scan_out), 64'd13);

    // Unicast back-to-back
    step(1'b1, 5'd3, 32'hAAAA0001, 5'd0, 1'b0, 5'd0, ALL);
    step(1'b1, 5'd7, 32'h55550002, 5'd0, 1'b0, 5'd0, ALL);
    chk("uni_first_enable", 64'(pe_enable), 64'h0008);
    chk("uni_first_value", 64'(pe_value), 64'hAAAA0001);
    idle(ALL);
    chk("uni_second_enable", 64'(pe_enable), 64'h0080);
    chk("uni_second_value", 64'(pe_value), 64'h55550002);
    idle(ALL);

    // Multicast with slow PE6
    step(1'b1, 5'd4, 32'h12345678, 5'b00011, 1'b0, 5'd0, ALL & ~14'h0040);
    idle(ALL & ~14'h0040);
    chk("mc_enable", 64'(pe_enable), 64'h00F0);
    for (int k = 0; k < 3; k++) begin
      idle(ALL & ~14'h0040);
      chk("mc_slow_enable", 64'(pe_enable), 64'h0040);
      chk("mc_slow_ready", 64'(ready), 64'd0);
    end
    idle(ALL);
    idle(ALL);
    chk("mc_drained_ready", 64'(ready), 64'd1);

    // Misses, then saturation
    for (int k = 0; k < 3; k++) step(1'b1, 5'd20, 32'hDEAD0000 + k, 5'd0, 1'b0, 5'd0, ALL);
    idle(ALL);
    chk("miss_three", 64'(miss_count), 64'd3);
    chk("miss_value_kept", 64'(pe_value), 64'h12345678);
    for (int k = 0; k < 65540; k++) step(1'b1, 5'd20, 32'd0, 5'd0, 1'b0, 5'd0, ALL);
    idle(ALL);
    chk("miss_saturated", 64'(miss_count), 64'hFFFF);

    // set_id during delivery: new IDs are id[i] = 13 - i
    step(1'b1, 5'd8, 32'hCAFE0008, 5'd0, 1'b0, 5'd0, ALL & ~14'h0100);
    for (int k = 0; k < N; k++)
      step(1'b1, 5'd0, 32'd0, 5'd0, 1'b1, 5'(k), (k < 3) ? (ALL & ~14'h0100) : ALL);
    step(1'b1, 5'd8, 32'hBEEF0005, 5'd0, 1'b0, 5'd0, ALL);
    idle(ALL);
    chk("new_id_target", 64'(pe_enable), 64'h0020);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      logic [N-1:0] prdy;
      for (int i = 0; i < N; i++) prdy[i] = ($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 15) == 0), 5'($urandom_range(0, 31)), prdy);
    end
    for (int k = 0; k < 3; k++) idle(ALL);

    // Reset mid-delivery
    load_ids_descending();
    step(1'b1, 5'd4, 32'h0F0F0F0F, 5'b00011, 1'b0, 5'd0, '0);
    idle('0);
    chk("pre_reset_enable", 64'(pe_enable), 64'h00F0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("async_reset_enable", 64'(pe_enable), 64'd0);
    chk("async_reset_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step(1'b1, 5'd0, 32'h00C0FFEE, 5'd0, 1'b0, 5'd0, ALL);
    idle(ALL);
    chk("post_reset_broadcast", 64'(pe_enable), 64'h3FFF);
    for (int k = 0; k < 3; k++) idle(ALL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xbus_mc.md
# xbus_mc

Multicast horizontal bus for one PE-array row: a successor to the unicast X-bus that broadcasts a tagged ifmap, filter or ipsum value to every PE whose scan-loaded ID matches the tag under a per-transfer don't-care mask. The bus registers the value in a one-entry delivery stage and tracks partial delivery per PE, so a slow PE does not stall PEs that are already ready. It sits between the GLB-side tag source and the PE_NUMS PEs of one row. The scan chain is compatible with the existing row ID-loading sequence.

## Interface
- PE_NUMS, 14, number of PEs on the row (1..32)
- ID_LEN, 5, width of the PE ID and tag ID
- VALUE_LEN, 32, payload width
- CNT_LEN, 16, width of the miss counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  source valid
- ready  out  1  bus can accept this cycle
- tag_value  in  ID_LEN+VALUE_LEN  {tag_id[ID_LEN-1:0], value[VALUE_LEN-1:0]}; ID in the upper bits
- tag_mask  in  ID_LEN  1 = ID bit is don't-care; all-zero = unicast
- set_id  in  1  scan-chain shift enable
- id_scan_in  in  ID_LEN  scan data into PE[0]
- id_scan_out  out  ID_LEN  ID held by PE[PE_NUMS-1]
- pe_value  out  VALUE_LEN  value in the delivery stage, common to all PEs
- pe_enable  out  PE_NUMS  per-PE valid; bit i is pending delivery to PE[i]
- pe_ready  in  PE_NUMS  per-PE ready
- busy  out  1  delivery stage non-empty (pe_enable != 0)
- miss_count  out  CNT_LEN  accepted tags that matched no PE, saturating

## Operation
- **ID scan chain**
  - On each edge with set_id=1: id[0] <= id_scan_in and id[i] <= id[i-1] for i=1..PE_NUMS-1.
  - Shifting in PE_NUMS-1, PE_NUMS-2, …, 0 on consecutive cycles leaves id[i]=i.
  - id_scan_out = id[PE_NUMS-1], registered.
- **Match**
  - PE[i] is targeted when ((id[i] ^ tag_id) & ~tag_mask) == 0.
  - The target bitmap is evaluated combinationally at accept time from the current IDs.
  - Later ID changes do not affect a transfer already accepted.
- **Accept**
  - A handshake occurs on an edge where enable & ready.
  - ready = !set_id & ((pending & ~pe_ready) == 0). This is combinational from pe_ready and set_id. pending is the pe_enable register.
- **Delivery stage**
  - On each edge, pending <= (pending & ~pe_ready).
  - If a handshake occurs with a non-zero target bitmap, the stage instead loads: pending <= bitmap, pe_value <= value.
  - Each PE consumes the value on the edge where its pe_enable and pe_ready bits are both 1. Bits clear independently, so partial delivery is allowed.
- **Miss**
  - A handshake with an all-zero bitmap does not load the stage.
  - pending still drains normally, and pe_value is unchanged.
  - miss_count increments by 1 and saturates at all-ones.
- **set_id**
  - While set_id=1, ready=0 and no new tag is accepted.
  - A pending transfer keeps draining using its captured bitmap.
- **Reset** (asynchronous, active-low): all id[i]=0, pending=0, pe_value=0, miss_count=0, id_scan_out=0.
  - Consequence: ready=1 after reset release.
  - Consequence: every PE matches tag_id 0 until IDs are loaded.
  - Reset asserted mid-delivery discards the transfer immediately (pe_enable=0 asynchronously).

## Timing
- Latency: a tag accepted at edge N appears on pe_value/pe_enable after edge N; PEs see it in cycle N+1.
- Throughput: one tag per cycle when every targeted PE holds pe_ready=1. A new accept in the same edge as the last delivery replaces the stage with no bubble.
- A PE with pe_ready=0 holds ready low. Other targeted PEs still consume and clear their bits.
- busy equals |pe_enable.
- tag_value and tag_mask are sampled only at the accept edge.
- ID update: id[] updates at the edge after each set_id cycle. A tag accepted in the cycle after set_id falls matches against the new IDs.

## Test plan
- **Reset, then scan load.** Drive rst=0 for 3 cycles, release, then set_id=1 for 14 cycles with id_scan_in=13..0.
  - During reset: outputs are 0.
  - After load: id[i]=i, and ready stays 0 during the shift.
  - id_scan_out sequence: 0 for the first 13 shifts, then 13 after the 14th.
- **Unicast, back-to-back.** All pe_ready=1, tag_mask=0. Send tags (id=3, 0xAAAA0001), then (id=7, 0x55550002) in consecutive cycles.
  - pe_enable = 0x0008, then 0x0080, one cycle each; pe_value matches; ready stays 1.
- **Multicast with a slow PE.** tag_id=4, tag_mask=5'b00011, so the targets are PE4..7, giving pe_enable=0x00F0. Hold pe_ready[6]=0 for 3 cycles.
  - Bits 4, 5 and 7 clear after one cycle.
  - pe_enable=0x0040 and ready=0 for 3 cycles.
  - Then the stage empties and ready=1.
- **Miss counting.** Send tag_id=20, mask 0 (no PE holds 20) three times, with the stage idle.
  - miss_count=3, pe_enable stays 0, pe_value unchanged.
  - Preload miss_count near saturation and confirm it stops at 0xFFFF.
- **set_id during delivery.** With pending=0x0100 and pe_ready[8]=0, raise set_id and shift new IDs.
  - pe_enable[8] persists until pe_ready[8]=1.
  - ready=0 throughout set_id.
  - A tag sent after set_id falls matches against the new IDs.
- **Reset mid-operation.** Assert rst while pe_enable=0x00F0.
  - pe_enable=0 immediately, without waiting for a clock edge.
  - After release: ready=1, and tag_id=0 targets all PEs (pe_enable=0x3FFF).
